// File: rtl/sha256_msg_schedule_if.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule_if
// Handshake bundle for the SHA-256 message-schedule stage.
//   in_valid  / in_ready  / in_word   : 32-bit message words from the padder
//   out_valid / out_ready / out_word  : expanded schedule words W[t]
//   out_index                         : t of the current out_word
//   out_last                          : marks W[ROUNDS-1]
// Modports:
//   slave  : the schedule block (consumes in_*, produces out_*)
//   master : the surrounding logic (produces in_*, consumes out_*)
// -----------------------------------------------------------------------------
interface sha256_msg_schedule_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [5:0]  out_index;
   logic        out_last;

   modport slave (
      input  in_valid, in_word, out_ready,
      output in_ready, out_valid, out_word, out_index, out_last
   );

   modport master (
      output in_valid, in_word, out_ready,
      input  in_ready, out_valid, out_word, out_index, out_last
   );
endinterface

// File: rtl/sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule
// SHA-256 message-schedule stage. Loads one 512-bit block as 16 serial 32-bit
// words (W[0] first), then streams W[0..ROUNDS-1], one word per handshake.
// A 16-word sliding window holds W[t..t+15]; each new word is computed on the
// fly from the window, so the full 64-word array is never stored.
//
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset (discards any partial block)
//   abort  : (only with SHA256_SCHED_ABORT_EN) return to LOAD on next edge
//   bus    : sha256_msg_schedule_if.slave handshake bundle
//
// Parameters:
//   ROUNDS : schedule words emitted per block, 17..64
//
// Optional feature macro: SHA256_SCHED_ABORT_EN
// -----------------------------------------------------------------------------
module sha256_msg_schedule #(
   parameter int ROUNDS = 64
) (
   input  logic clk,
   input  logic rst,
`ifdef SHA256_SCHED_ABORT_EN
   input  logic abort,
`endif
   sha256_msg_schedule_if.slave bus
);

   localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

   typedef enum logic {
      LOAD,
      EMIT
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] win_q [16];
   logic [31:0] win_d [16];
   logic [31:0] next_w;

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      // ROTR7 ^ ROTR18 ^ SHR3
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      // ROTR17 ^ ROTR19 ^ SHR10
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // W[t+16] from W[t..t+15]; 32-bit sum drops the carries out of bit 31.
   assign next_w = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

   always_comb begin
      // NOTE: every output of this block gets a default before the case so no
      // path leaves a variable unassigned, which would infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      win_d        = win_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;

      unique case (state_q)
         LOAD: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               win_d[cnt_q[3:0]] = bus.in_word;
               if (cnt_q == 6'd15) begin
                  state_d = EMIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         EMIT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               for (int i = 0; i < 15; i++) begin
                  win_d[i] = win_q[i+1];
               end
               win_d[15] = next_w;
               if (cnt_q == LAST_IDX) begin
                  state_d = LOAD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         default: begin
            state_d = LOAD;
            cnt_d   = '0;
         end
      endcase

`ifdef SHA256_SCHED_ABORT_EN
      // Abort cancels whatever handshake fired this cycle; the window is left
      // untouched because the next block overwrites all of it anyway.
      if (abort) begin
         state_d = LOAD;
         cnt_d   = '0;
         win_d   = win_q;
      end
`endif
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         // NOTE: the window is cleared on reset because out_word is driven
         // straight from win_q[0] and must read zero after reset.
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
      end
   end

   assign bus.out_word  = win_q[0];
   assign bus.out_index = cnt_q;
   assign bus.out_last  = (state_q == EMIT) && (cnt_q == LAST_IDX);

endmodule
